// File: rtl/mac_seq.sv
// rtl/mac_seq.sv - AXI4-Lite master sequencing one multiply-accumulate on a MAC slave
// Optional STATUS poll timeout is enabled by defining MAC_SEQ_TIMEOUT_EN.
module mac_seq #(
  parameter int POLL_MAX = 255,
  parameter int A_W      = 12
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [95:0]    op_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [31:0]    res_data,
  output logic           res_err,
  output logic [A_W-1:0] m_awaddr,
  output logic           m_awvalid,
  input  logic           m_awready,
  output logic [31:0]    m_wdata,
  output logic [3:0]     m_wstrb,
  output logic           m_wvalid,
  input  logic           m_wready,
  input  logic [1:0]     m_bresp,
  input  logic           m_bvalid,
  output logic           m_bready,
  output logic [A_W-1:0] m_araddr,
  output logic           m_arvalid,
  input  logic           m_arready,
  input  logic [31:0]    m_rdata,
  input  logic [1:0]     m_rresp,
  input  logic           m_rvalid,
  output logic           m_rready
);

  if (POLL_MAX < 1 || POLL_MAX > 65535) begin : g_poll_max_range
    $error("mac_seq: POLL_MAX must be within 1..65535");
  end

  localparam logic [A_W-1:0] ADDR_F1     = A_W'('h000);
  localparam logic [A_W-1:0] ADDR_F2     = A_W'('h004);
  localparam logic [A_W-1:0] ADDR_A1     = A_W'('h008);
  localparam logic [A_W-1:0] ADDR_CTRL   = A_W'('h00C);
  localparam logic [A_W-1:0] ADDR_STATUS = A_W'('h010);
  localparam logic [A_W-1:0] ADDR_RESULT = A_W'('h014);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_F1,
    S_WR_F2,
    S_WR_A1,
    S_WR_GO,
    S_POLL,
    S_RD_RES,
    S_OUT
  } state_t;

  state_t      state;
  logic [31:0] f2_q;
  logic [31:0] a1_q;
  logic        aw_done;
  logic        w_done;

  logic aw_hs;
  logic w_hs;
  logic b_fire;
  logic ar_hs;
  logic r_fire;

`ifdef MAC_SEQ_TIMEOUT_EN
  logic [15:0] poll_cnt;
`endif

  assign m_wstrb = 4'hF;
  assign aw_hs   = m_awvalid && m_awready;
  assign w_hs    = m_wvalid && m_wready;
  // B is only honoured once both AW and W are done, possibly all in one cycle.
  assign b_fire  = m_bvalid && m_bready && (aw_done || aw_hs) && (w_done || w_hs);
  assign ar_hs   = m_arvalid && m_arready;
  assign r_fire  = m_rvalid && m_rready;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= S_IDLE;
      op_ready  <= 1'b1;
      res_valid <= 1'b0;
      res_data  <= 32'd0;
      res_err   <= 1'b0;
      m_awaddr  <= '0;
      m_awvalid <= 1'b0;
      m_wdata   <= 32'd0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_araddr  <= '0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      f2_q      <= 32'd0;
      a1_q      <= 32'd0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
      poll_cnt  <= 16'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            op_ready  <= 1'b0;
            f2_q      <= op_data[63:32];
            a1_q      <= op_data[95:64];
            state     <= S_WR_F1;
            m_awaddr  <= ADDR_F1;
            m_wdata   <= op_data[31:0];
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            m_bready  <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
`ifdef MAC_SEQ_TIMEOUT_EN
            poll_cnt  <= 16'd0;
`endif
          end
        end

        S_WR_F1, S_WR_F2, S_WR_A1, S_WR_GO: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if (b_fire) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (m_bresp != 2'b00) begin
              m_bready  <= 1'b0;
              state     <= S_OUT;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= 32'd0;
            end else begin
              case (state)
                S_WR_F1: begin
                  state     <= S_WR_F2;
                  m_awaddr  <= ADDR_F2;
                  m_wdata   <= f2_q;
                  m_awvalid <= 1'b1;
                  m_wvalid  <= 1'b1;
                end
                S_WR_F2: begin
                  state     <= S_WR_A1;
                  m_awaddr  <= ADDR_A1;
                  m_wdata   <= a1_q;
                  m_awvalid <= 1'b1;
                  m_wvalid  <= 1'b1;
                end
                S_WR_A1: begin
                  state     <= S_WR_GO;
                  m_awaddr  <= ADDR_CTRL;
                  m_wdata   <= 32'd1;
                  m_awvalid <= 1'b1;
                  m_wvalid  <= 1'b1;
                end
                default: begin
                  m_bready  <= 1'b0;
                  state     <= S_POLL;
                  m_araddr  <= ADDR_STATUS;
                  m_arvalid <= 1'b1;
                end
              endcase
            end
          end
        end

        S_POLL, S_RD_RES: begin
          if (ar_hs) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
          end
          if (r_fire) begin
            m_rready <= 1'b0;
            if (m_rresp != 2'b00) begin
              state     <= S_OUT;
              res_valid <= 1'b1;
              res_err   <= 1'b1;
              res_data  <= 32'd0;
            end else if (state == S_RD_RES) begin
              state     <= S_OUT;
              res_valid <= 1'b1;
              res_err   <= 1'b0;
              res_data  <= m_rdata;
            end else if (m_rdata[0]) begin
              state     <= S_RD_RES;
              m_araddr  <= ADDR_RESULT;
              m_arvalid <= 1'b1;
            end else begin
`ifdef MAC_SEQ_TIMEOUT_EN
              // This read was the POLL_MAX-th one and the slave is still busy.
              if (poll_cnt == 16'(POLL_MAX - 1)) begin
                state     <= S_OUT;
                res_valid <= 1'b1;
                res_err   <= 1'b1;
                res_data  <= 32'd0;
              end else begin
                poll_cnt  <= poll_cnt + 16'd1;
                m_arvalid <= 1'b1;
              end
`else
              m_arvalid <= 1'b1;
`endif
            end
          end
        end

        S_OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq.sv
// tb/tb_mac_seq.sv - directed bench for mac_seq against a small AXI4-Lite MAC slave model
// Exercises the MAC_SEQ_TIMEOUT_EN path when that macro is defined.
module tb_mac_seq;
  localparam int A_W = 12;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           op_valid;
  logic           op_ready;
  logic [95:0]    op_data;
  logic           res_valid;
  logic           res_ready;
  logic [31:0]    res_data;
  logic           res_err;
  logic [A_W-1:0] m_awaddr;
  logic           m_awvalid;
  logic           m_awready;
  logic [31:0]    m_wdata;
  logic [3:0]     m_wstrb;
  logic           m_wvalid;
  logic           m_wready;
  logic [1:0]     m_bresp;
  logic           m_bvalid;
  logic           m_bready;
  logic [A_W-1:0] m_araddr;
  logic           m_arvalid;
  logic           m_arready;
  logic [31:0]    m_rdata;
  logic [1:0]     m_rresp;
  logic           m_rvalid;
  logic           m_rready;

  mac_seq #(.POLL_MAX(4), .A_W(A_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Slave knobs, set by the stimulus process
  int wdelay     = 0;
  int done_after = 0;
  int err_at     = -1;
  int st_base    = 0;

  // Slave state and transaction log
  int             aw_hs_n = 0;
  int             w_hs_n  = 0;
  int             b_n     = 0;
  int             st_reads = 0;
  int             res_reads = 0;
  int             wcnt;
  logic           aw_got;
  logic           w_got;
  logic [A_W-1:0] cap_addr;
  logic [31:0]    cap_data;
  logic [31:0]    reg_f1, reg_f2, reg_a1;
  logic [A_W-1:0] wr_addr_log [64];
  logic [31:0]    wr_data_log [64];
  logic [A_W-1:0] b_addr;
  logic [31:0]    b_data;

  assign m_awready = 1'b1;
  assign m_arready = 1'b1;
  assign m_bresp   = 2'b00;
  assign m_wready  = (wdelay == 0) ? 1'b1 : (aw_got && wcnt >= wdelay);
  assign m_bvalid  = (aw_got || (m_awvalid && m_awready)) && (w_got || (m_wvalid && m_wready));
  assign b_addr    = (m_awvalid && m_awready) ? m_awaddr : cap_addr;
  assign b_data    = (m_wvalid && m_wready) ? m_wdata : cap_data;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      wcnt     <= 0;
      m_rvalid <= 1'b0;
      m_rdata  <= 32'd0;
      m_rresp  <= 2'b00;
    end else begin
      if (m_awvalid && m_awready) begin
        aw_got   <= 1'b1;
        wcnt     <= 1;
        cap_addr <= m_awaddr;
        aw_hs_n  <= aw_hs_n + 1;
      end else if (aw_got) begin
        wcnt <= wcnt + 1;
      end
      if (m_wvalid && m_wready) begin
        w_got    <= 1'b1;
        cap_data <= m_wdata;
        w_hs_n   <= w_hs_n + 1;
      end
      if (m_bvalid && m_bready) begin
        wr_addr_log[b_n % 64] <= b_addr;
        wr_data_log[b_n % 64] <= b_data;
        b_n    <= b_n + 1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (b_addr == 12'h000) reg_f1 <= b_data;
        if (b_addr == 12'h004) reg_f2 <= b_data;
        if (b_addr == 12'h008) reg_a1 <= b_data;
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        if (m_araddr == 12'h010) begin
          m_rdata  <= {31'd0, (st_reads - st_base) >= done_after};
          m_rresp  <= ((st_reads - st_base) == err_at) ? 2'b10 : 2'b00;
          st_reads <= st_reads + 1;
        end else if (m_araddr == 12'h014) begin
          m_rdata   <= reg_a1 + reg_f1 * reg_f2;
          m_rresp   <= 2'b00;
          res_reads <= res_reads + 1;
        end else begin
          m_rdata <= 32'd0;
          m_rresp <= 2'b00;
        end
      end
    end
  end

  task automatic run_op(input logic [31:0] f1, input logic [31:0] f2, input logic [31:0] a1,
                        input int hold, output int lat, output logic [31:0] data, output logic err);
    int guard;
    logic stable;
    logic [31:0] d0;
    logic e0;
    st_base = st_reads;
    @(negedge clk);
    op_data  = {a1, f2, f1};
    op_valid = 1'b1;
    guard = 0;
    while (!op_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("op_ready_idle", op_ready, 1);
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    op_data  = '0;
    lat = 0;
    while (!res_valid && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("res_valid_seen", res_valid, 1);
    d0 = res_data;
    e0 = res_err;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!res_valid || res_data !== d0 || res_err !== e0 || op_ready) stable = 1'b0;
    end
    if (hold > 0) check("out_stable", stable, 1);
    data = res_data;
    err  = res_err;
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    check("idle_after_out", {op_ready, res_valid}, 2'b10);
  endtask

  task automatic check_writes(input int base, input logic [31:0] f1, input logic [31:0] f2,
                              input logic [31:0] a1);
    logic [31:0] exp_d [4];
    exp_d[0] = f1;
    exp_d[1] = f2;
    exp_d[2] = a1;
    exp_d[3] = 32'd1;
    for (int i = 0; i < 4; i++) begin
      check("wr_addr", {20'd0, wr_addr_log[(base + i) % 64]}, 32'(i * 4));
      check("wr_data", wr_data_log[(base + i) % 64], exp_d[i]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] d;
    logic e;
    int b0, aw0, w0, s0, r0;

    op_valid  = 1'b0;
    op_data   = '0;
    res_ready = 1'b0;
    arst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {op_ready, res_valid, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready},
          7'b1000000);
    arst_n = 1'b1;
    @(negedge clk);
    check("rst_res", {res_err, res_data}, 33'd0);
    check("wstrb", m_wstrb, 4'hF);

    // zero-wait slave, done on first poll
    b0 = b_n; aw0 = aw_hs_n; w0 = w_hs_n; s0 = st_reads; r0 = res_reads;
    run_op(3, 4, 5, 0, lat, d, e);
    check("t1_latency", lat, 8);
    check("t1_data", d, 32'h11);
    check("t1_err", e, 0);
    check("t1_b_count", b_n - b0, 4);
    check("t1_aw_count", aw_hs_n - aw0, 4);
    check("t1_w_count", w_hs_n - w0, 4);
    check("t1_status_reads", st_reads - s0, 1);
    check("t1_result_reads", res_reads - r0, 1);
    check_writes(b0, 3, 4, 5);

    // W ready lags AW by 3 cycles on every write
    wdelay = 3;
    b0 = b_n; aw0 = aw_hs_n; w0 = w_hs_n;
    run_op(3, 4, 5, 0, lat, d, e);
    check("t2_data", d, 32'h11);
    check("t2_err", e, 0);
    check("t2_b_count", b_n - b0, 4);
    check("t2_aw_count", aw_hs_n - aw0, 4);
    check("t2_w_count", w_hs_n - w0, 4);
    check_writes(b0, 3, 4, 5);
    wdelay = 0;

    // two extra polls: 7*6+100 = 142
    done_after = 2;
    s0 = st_reads; r0 = res_reads;
    run_op(7, 6, 100, 0, lat, d, e);
    check("t3_latency", lat, 12);
    check("t3_data", d, 32'h8E);
    check("t3_status_reads", st_reads - s0, 3);
    check("t3_result_reads", res_reads - r0, 1);

    // error response on the second STATUS read
    done_after = 5;
    err_at = 1;
    s0 = st_reads; r0 = res_reads;
    run_op(9, 9, 9, 0, lat, d, e);
    check("t4_err", e, 1);
    check("t4_data", d, 0);
    check("t4_status_reads", st_reads - s0, 2);
    check("t4_result_reads", res_reads - r0, 0);
    err_at = -1;
    done_after = 0;

    // consumer stalls 5 cycles: 2*16+1 = 33
    run_op(2, 16, 1, 5, lat, d, e);
    check("t5_latency", lat, 8);
    check("t5_data", d, 32'h21);
    check("t5_err", e, 0);

    // reset while F2 write is in flight
    b0 = b_n;
    @(negedge clk);
    op_data  = {32'd5, 32'd4, 32'd3};
    op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("t6_aw_in_wr_f2", {m_awvalid, 20'd0, m_awaddr}, {1'b1, 20'd0, 12'h004});
    arst_n = 1'b0;
    #1;
    check("t6_valids_in_rst", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, res_valid}, 6'd0);
    @(negedge clk);
    arst_n = 1'b1;
    @(negedge clk);
    check("t6_op_ready", op_ready, 1);
    check("t6_abandoned_writes", b_n - b0, 1);
    b0 = b_n;
    run_op(3, 4, 5, 0, lat, d, e);
    check("t6_latency", lat, 8);
    check("t6_data", d, 32'h11);
    check_writes(b0, 3, 4, 5);

`ifdef MAC_SEQ_TIMEOUT_EN
    // done never set: POLL_MAX=4 reads then timeout
    done_after = 1000;
    s0 = st_reads; r0 = res_reads;
    run_op(1, 1, 1, 0, lat, d, e);
    check("t7_status_reads", st_reads - s0, 4);
    check("t7_err", e, 1);
    check("t7_data", d, 0);
    check("t7_latency", lat, 12);
    check("t7_result_reads", res_reads - r0, 0);
`else
    // no timeout: six busy polls beyond POLL_MAX still complete, 1*2+3 = 5
    done_after = 6;
    s0 = st_reads;
    run_op(1, 2, 3, 0, lat, d, e);
    check("t7_status_reads", st_reads - s0, 7);
    check("t7_err", e, 0);
    check("t7_data", d, 5);
    check("t7_latency", lat, 20);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
